instr_mem_loader: RTL and testbench
===================================

# instr_mem_loader

Program loader for the byte-addressed, little-endian instruction memory. It accepts a byte stream over a valid/ready handshake and packs bytes into 32-bit words, byte 0 in the least significant lane. It issues one word write per packed word, with byte strobes, to the memory's write port. It sits between the host link (UART/debug receiver) and the instruction memory, and its write port is the counterpart of the memory's combinational read port.

## Interface
Parameters:
- DEPTH_BYTES, 128: instruction memory size in bytes; must be a multiple of 4.
- LEN_W, 8: width of LEN; must satisfy 2^LEN_W > DEPTH_BYTES.

Ports:
- CLK  in  1  system clock; all state changes on the rising edge.
- RST_N  in  1  synchronous active-low reset; one clock, synchronous reset, active low.
- START  in  1  one-cycle load request; sampled only in IDLE.
- LEN  in  LEN_W  number of payload bytes; sampled with START.
- BYTE_IN  in  8  stream data byte.
- BYTE_VALID  in  1  stream byte present.
- BYTE_READY  out  1  loader can accept a byte.
- WE  out  1  one-cycle word write strobe to the instruction memory.
- WADDR  out  32  word-aligned byte address of the write (bits [1:0] = 0).
- WDATA  out  32  packed word, little-endian.
- WSTRB  out  4  byte-lane enables; bit k enables WDATA[8k+7:8k].
- BUSY  out  1  high in every state except IDLE.
- DONE  out  1  one-cycle pulse when the load completes successfully.
- ERR  out  1  one-cycle pulse when a load is rejected or fails.

## Operation
- States:
  - IDLE: BYTE_READY=0.
  - LOAD: BYTE_READY=1.
  - WRITE: WE=1, BYTE_READY=0.
  - CHK: only when `LOADER_CHECKSUM_EN` is defined.
  - FIN: DONE or ERR pulse.
- IDLE, START=1:
  - LEN=0: go to FIN with DONE. No writes occur.
  - LEN>DEPTH_BYTES: go to FIN with ERR. No writes occur.
  - Otherwise: latch LEN into the remaining-byte counter, clear the byte counter and the pack register, and go to LOAD.
- LOAD:
  - A byte is accepted on BYTE_VALID & BYTE_READY.
  - Byte n (n counts from 0) is placed in WDATA lane n%4, and strobe bit n%4 is set.
  - The remaining-byte counter decrements on each accepted byte.
  - Go to WRITE when lane 3 is filled or the remaining count reaches 0.
- WRITE:
  - WE=1 for exactly one cycle.
  - WADDR = 4*floor(n/4) of the word's first byte.
  - WSTRB holds only the filled lanes; a final partial word carries unfilled lanes as 0.
  - Next state: if bytes remain, clear the pack register and strobes and return to LOAD. Otherwise go to CHK if `LOADER_CHECKSUM_EN` is defined, else go to FIN with DONE.
- FIN: pulse DONE or ERR for one cycle, then return to IDLE.
- START outside IDLE is ignored. LEN changes outside IDLE are ignored.
- Reset mid-load returns to IDLE and clears all outputs and counters. A partially packed word is discarded and never written.
- The address counter never wraps, because LEN is bounded by DEPTH_BYTES.

## Timing
- Reset values: BYTE_READY=0, WE=0, WADDR=0, WDATA=0, WSTRB=0, BUSY=0, DONE=0, ERR=0. State is IDLE.
- All outputs are registered. There are no combinational paths from input to output.
- START accepted in cycle t: BUSY=1 and BYTE_READY=1 from cycle t+1.
- 4th byte of a word accepted in cycle t: WE=1 in cycle t+1, and BYTE_READY is low in that cycle.
  - Peak throughput is 4 bytes per 5 cycles.
- Last byte accepted in cycle t: WE in cycle t+1, DONE in cycle t+2, BUSY=0 in cycle t+3.
- LEN=0 or an oversize LEN with START in cycle t: DONE or ERR in cycle t+1.
- BYTE_VALID may be held low for any number of cycles. The loader waits indefinitely without timeout.

## Configuration
- `LOADER_CHECKSUM_EN` defined:
  - After the final WRITE, the loader enters CHK with BYTE_READY=1 and accepts exactly one extra byte.
  - That byte is compared with the 8-bit modulo-256 sum of all payload bytes.
  - Match: DONE on the next cycle. Mismatch: ERR on the next cycle instead of DONE.
  - Already-written words are not rolled back.
  - LEN=0 skips CHK and pulses DONE.
- `LOADER_CHECKSUM_EN` undefined: the CHK state and the sum register are absent, and the loader consumes exactly LEN bytes.

## Test plan
- START, LEN=8, bytes 13,00,00,93,FF,00,11,22 with VALID held high:
  - Required response: WE at WADDR=0 with WDATA=9300_0013, WSTRB=F; WE at WADDR=4 with WDATA=2211_00FF, WSTRB=F; DONE 2 cycles after the last byte.
- LEN=6, bytes 01..06:
  - Required response: second write WADDR=4, WDATA=0000_0605, WSTRB=3; DONE follows.
- LEN=0, then LEN=132 with DEPTH_BYTES=128:
  - Required response: DONE one cycle after START, then ERR one cycle after START; WE never asserted; BYTE_READY stays 0.
- LEN=4, BYTE_VALID toggled 1,0,0,1,1,0,1, plus a second START pulse mid-load:
  - Required response: exactly one write of 4 bytes in order; the second START is ignored.
- Reset asserted after 3 of LEN=4 bytes:
  - Required response: no WE; all outputs 0 the cycle after reset; a new load starting at WADDR=0 proceeds normally.
- With `LOADER_CHECKSUM_EN`, LEN=2, bytes 10,20:
  - Checksum byte 30: DONE is required.
  - Checksum byte 31: ERR is required and DONE is not asserted.

Source files
------------

// File: rtl/instr_mem_loader_if.sv
// Byte-stream handshake plus instruction-memory write port for instr_mem_loader.
// The slave modport is the loader side; the master modport is the host/memory side.
interface instr_mem_loader_if;
   logic [7:0]  BYTE_IN;
   logic        BYTE_VALID;
   logic        BYTE_READY;
   logic        WE;
   logic [31:0] WADDR;
   logic [31:0] WDATA;
   logic [3:0]  WSTRB;

   modport master (
      output BYTE_IN, BYTE_VALID,
      input  BYTE_READY, WE, WADDR, WDATA, WSTRB
   );

   modport slave (
      input  BYTE_IN, BYTE_VALID,
      output BYTE_READY, WE, WADDR, WDATA, WSTRB
   );
endinterface

// File: rtl/instr_mem_loader.sv
// Packs a byte stream into little-endian 32-bit words and writes them to instruction memory.
// Optional trailing checksum byte when LOADER_CHECKSUM_EN is defined.
module instr_mem_loader #(
   parameter int DEPTH_BYTES = 128,
   parameter int LEN_W       = 8
) (
   input  logic             CLK,
   input  logic             RST_N,
   input  logic             START,
   input  logic [LEN_W-1:0] LEN,
   instr_mem_loader_if.slave bus,
   output logic             BUSY,
   output logic             DONE,
   output logic             ERR
);

   localparam logic [LEN_W-1:0] DEPTH_L = LEN_W'(DEPTH_BYTES);

   typedef enum logic [2:0] {
      S_IDLE,
      S_LOAD,
      S_WRITE,
`ifdef LOADER_CHECKSUM_EN
      S_CHK,
`endif
      S_FIN
   } state_e;

   state_e           state_q, state_d;
   logic [LEN_W-1:0] rem_q, rem_d;
   logic [LEN_W-1:0] cnt_q, cnt_d;
   logic [31:0]      pack_q, pack_d;
   logic [3:0]       strb_q, strb_d;
   logic [31:0]      waddr_q, waddr_d;
   logic             fin_err_d;
   logic             ready_q, we_q, busy_q, done_q, err_q;
   logic             accept;
   logic [1:0]       lane;
`ifdef LOADER_CHECKSUM_EN
   logic [7:0]       sum_q, sum_d;
`endif

   assign accept = bus.BYTE_VALID & ready_q;
   assign lane   = cnt_q[1:0];

   always_ff @(posedge CLK) begin
      if (!RST_N) begin
         state_q <= S_IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   // Outputs are flopped from the next state so nothing combinational reaches a port.
   always_ff @(posedge CLK) begin
      if (!RST_N) begin
         rem_q   <= '0;
         cnt_q   <= '0;
         pack_q  <= '0;
         strb_q  <= '0;
         waddr_q <= '0;
         ready_q <= 1'b0;
         we_q    <= 1'b0;
         busy_q  <= 1'b0;
         done_q  <= 1'b0;
         err_q   <= 1'b0;
`ifdef LOADER_CHECKSUM_EN
         sum_q   <= '0;
`endif
      end else begin
         rem_q   <= rem_d;
         cnt_q   <= cnt_d;
         pack_q  <= pack_d;
         strb_q  <= strb_d;
         waddr_q <= waddr_d;
`ifdef LOADER_CHECKSUM_EN
         ready_q <= (state_d == S_LOAD) || (state_d == S_CHK);
         sum_q   <= sum_d;
`else
         ready_q <= (state_d == S_LOAD);
`endif
         we_q    <= (state_d == S_WRITE);
         busy_q  <= (state_d != S_IDLE);
         done_q  <= (state_d == S_FIN) && !fin_err_d;
         err_q   <= (state_d == S_FIN) && fin_err_d;
      end
   end

   always_comb begin
      state_d   = state_q;
      rem_d     = rem_q;
      cnt_d     = cnt_q;
      pack_d    = pack_q;
      strb_d    = strb_q;
      waddr_d   = waddr_q;
      fin_err_d = 1'b0;
`ifdef LOADER_CHECKSUM_EN
      sum_d     = sum_q;
`endif
      unique case (state_q)
         S_IDLE: begin
            if (START) begin
               if (LEN == '0) begin
                  state_d = S_FIN;
               end else if (LEN > DEPTH_L) begin
                  state_d   = S_FIN;
                  fin_err_d = 1'b1;
               end else begin
                  rem_d   = LEN;
                  cnt_d   = '0;
                  pack_d  = '0;
                  strb_d  = '0;
                  waddr_d = '0;
`ifdef LOADER_CHECKSUM_EN
                  sum_d   = '0;
`endif
                  state_d = S_LOAD;
               end
            end
         end
         S_LOAD: begin
            if (accept) begin
               pack_d[{lane, 3'b000} +: 8] = bus.BYTE_IN;
               strb_d[lane]                = 1'b1;
               rem_d                       = rem_q - 1'b1;
               cnt_d                       = cnt_q + 1'b1;
`ifdef LOADER_CHECKSUM_EN
               sum_d                       = sum_q + bus.BYTE_IN;
`endif
               if ((lane == 2'd3) || (rem_q == LEN_W'(1))) begin
                  state_d = S_WRITE;
               end
            end
         end
         S_WRITE: begin
            if (rem_q != '0) begin
               pack_d  = '0;
               strb_d  = '0;
               waddr_d = waddr_q + 32'd4;
               state_d = S_LOAD;
            end else begin
`ifdef LOADER_CHECKSUM_EN
               state_d = S_CHK;
`else
               state_d = S_FIN;
`endif
            end
         end
`ifdef LOADER_CHECKSUM_EN
         // Words already written stay in memory even if the checksum fails.
         S_CHK: begin
            if (accept) begin
               state_d   = S_FIN;
               fin_err_d = (bus.BYTE_IN != sum_q);
            end
         end
`endif
         S_FIN: begin
            state_d = S_IDLE;
         end
         default: begin
            state_d = S_IDLE;
         end
      endcase
   end

   assign bus.BYTE_READY = ready_q;
   assign bus.WE         = we_q;
   assign bus.WADDR      = waddr_q;
   assign bus.WDATA      = pack_q;
   assign bus.WSTRB      = strb_q;
   assign BUSY           = busy_q;
   assign DONE           = done_q;
   assign ERR            = err_q;

endmodule

// File: tb/tb_instr_mem_loader.sv
// Directed self-checking bench for instr_mem_loader; also exercises the checksum
// path when built with LOADER_CHECKSUM_EN.
module tb_instr_mem_loader;

   logic       CLK;
   logic       RST_N;
   logic       START;
   logic [7:0] LEN;
   logic       BUSY;
   logic       DONE;
   logic       ERR;

   int nAsserts = 0;
   int nFails   = 0;
   int weCount  = 0;
   int weBase;

   instr_mem_loader_if bus ();

   instr_mem_loader #(
      .DEPTH_BYTES(128),
      .LEN_W      (8)
   ) dut (
      .CLK  (CLK),
      .RST_N(RST_N),
      .START(START),
      .LEN  (LEN),
      .bus  (bus.slave),
      .BUSY (BUSY),
      .DONE (DONE),
      .ERR  (ERR)
   );

   initial CLK = 1'b0;
   always #5 CLK = ~CLK;

   // Independent count of write strobes seen by the memory side.
   always @(negedge CLK) begin
      if (bus.WE === 1'b1) weCount++;
   end

   initial begin
      #200000;
      $display("[TB] FAIL watchdog: observed timeout required completion");
      $fatal(1, "[TB] simulation timeout");
   end

   task automatic checkOutput(input string tag, input logic [31:0] observed,
                              input logic [31:0] expected);
      nAsserts++;
      assert (observed === expected) else begin
         nFails++;
         $error("[TB] FAIL %s: observed %h expected %h", tag, observed, expected);
      end
   endtask

   // Drive one cycle of inputs, then advance to just after the next rising edge.
   task automatic applyStimulus(input logic start, input logic [7:0] len,
                                input logic [7:0] b, input logic valid);
      START          = start;
      LEN            = len;
      bus.BYTE_IN    = b;
      bus.BYTE_VALID = valid;
      @(posedge CLK);
      #1;
   endtask

   // Offer a byte with VALID high until the loader takes it (bounded wait).
   task automatic pushByte(input logic [7:0] b);
      bit taken;
      taken          = 1'b0;
      START          = 1'b0;
      bus.BYTE_IN    = b;
      bus.BYTE_VALID = 1'b1;
      for (int i = 0; i < 8 && !taken; i++) begin
         taken = (bus.BYTE_READY === 1'b1);
         @(posedge CLK);
         #1;
      end
      checkOutput("byte_accepted", {31'd0, taken}, 32'd1);
   endtask

   // Called in the cycle WE is high for the final word; checks DONE/ERR timing.
   task automatic endLoad(input logic [7:0] csum, input logic expErr);
`ifdef LOADER_CHECKSUM_EN
      pushByte(csum);
      bus.BYTE_VALID = 1'b0;
`else
      applyStimulus(1'b0, 8'd0, csum, 1'b0);
`endif
      checkOutput("fin_done", {31'd0, DONE}, {31'd0, ~expErr});
      checkOutput("fin_err", {31'd0, ERR}, {31'd0, expErr});
      checkOutput("fin_busy", {31'd0, BUSY}, 32'd1);
      applyStimulus(1'b0, 8'd0, 8'h00, 1'b0);
      checkOutput("idle_busy", {31'd0, BUSY}, 32'd0);
      checkOutput("idle_done", {31'd0, DONE}, 32'd0);
   endtask

   task automatic checkWrite(input string tag, input logic [31:0] addr,
                             input logic [31:0] data, input logic [3:0] strb);
      checkOutput({tag, "_we"}, {31'd0, bus.WE}, 32'd1);
      checkOutput({tag, "_ready"}, {31'd0, bus.BYTE_READY}, 32'd0);
      checkOutput({tag, "_waddr"}, bus.WADDR, addr);
      checkOutput({tag, "_wdata"}, bus.WDATA, data);
      checkOutput({tag, "_wstrb"}, {28'd0, bus.WSTRB}, {28'd0, strb});
   endtask

   task automatic checkAllZero(input string tag);
      checkOutput({tag, "_ready"}, {31'd0, bus.BYTE_READY}, 32'd0);
      checkOutput({tag, "_we"}, {31'd0, bus.WE}, 32'd0);
      checkOutput({tag, "_waddr"}, bus.WADDR, 32'd0);
      checkOutput({tag, "_wdata"}, bus.WDATA, 32'd0);
      checkOutput({tag, "_wstrb"}, {28'd0, bus.WSTRB}, 32'd0);
      checkOutput({tag, "_busy"}, {31'd0, BUSY}, 32'd0);
      checkOutput({tag, "_done"}, {31'd0, DONE}, 32'd0);
      checkOutput({tag, "_err"}, {31'd0, ERR}, 32'd0);
   endtask

   initial begin
      RST_N          = 1'b0;
      START          = 1'b0;
      LEN            = 8'd0;
      bus.BYTE_IN    = 8'd0;
      bus.BYTE_VALID = 1'b0;
      applyStimulus(1'b0, 8'd0, 8'h00, 1'b0);
      applyStimulus(1'b0, 8'd0, 8'h00, 1'b0);
      checkAllZero("reset");
      RST_N = 1'b1;
      applyStimulus(1'b0, 8'd0, 8'h00, 1'b0);

      // Two full words with VALID held high.
      $display("[TB] LEN=8 two full words");
      weBase = weCount;
      applyStimulus(1'b1, 8'd8, 8'h00, 1'b0);
      checkOutput("t1_busy", {31'd0, BUSY}, 32'd1);
      checkOutput("t1_ready", {31'd0, bus.BYTE_READY}, 32'd1);
      pushByte(8'h13); pushByte(8'h00); pushByte(8'h00); pushByte(8'h93);
      checkWrite("t1_w0", 32'h0000_0000, 32'h9300_0013, 4'hF);
      pushByte(8'hFF); pushByte(8'h00); pushByte(8'h11); pushByte(8'h22);
      checkWrite("t1_w1", 32'h0000_0004, 32'h2211_00FF, 4'hF);
      endLoad(8'hD8, 1'b0);
      checkOutput("t1_wecount", weCount - weBase, 32'd2);

      // Partial final word.
      $display("[TB] LEN=6 partial last word");
      weBase = weCount;
      applyStimulus(1'b1, 8'd6, 8'h00, 1'b0);
      pushByte(8'h01); pushByte(8'h02); pushByte(8'h03); pushByte(8'h04);
      checkWrite("t2_w0", 32'h0000_0000, 32'h0403_0201, 4'hF);
      pushByte(8'h05); pushByte(8'h06);
      checkWrite("t2_w1", 32'h0000_0004, 32'h0000_0605, 4'h3);
      endLoad(8'h15, 1'b0);
      checkOutput("t2_wecount", weCount - weBase, 32'd2);

      // Empty and oversize requests.
      $display("[TB] LEN=0 and LEN=132");
      weBase = weCount;
      applyStimulus(1'b1, 8'd0, 8'h00, 1'b0);
      checkOutput("t3_len0_done", {31'd0, DONE}, 32'd1);
      checkOutput("t3_len0_err", {31'd0, ERR}, 32'd0);
      checkOutput("t3_len0_ready", {31'd0, bus.BYTE_READY}, 32'd0);
      applyStimulus(1'b0, 8'd0, 8'h00, 1'b0);
      checkOutput("t3_len0_idle", {31'd0, BUSY}, 32'd0);
      applyStimulus(1'b1, 8'd132, 8'h00, 1'b0);
      checkOutput("t3_big_err", {31'd0, ERR}, 32'd1);
      checkOutput("t3_big_done", {31'd0, DONE}, 32'd0);
      checkOutput("t3_big_ready", {31'd0, bus.BYTE_READY}, 32'd0);
      applyStimulus(1'b0, 8'd0, 8'h00, 1'b0);
      checkOutput("t3_big_err_off", {31'd0, ERR}, 32'd0);
      checkOutput("t3_big_ready2", {31'd0, bus.BYTE_READY}, 32'd0);
      checkOutput("t3_wecount", weCount - weBase, 32'd0);

      // Gapped VALID with a stray START mid-load.
      $display("[TB] LEN=4 gapped valid, second START");
      weBase = weCount;
      applyStimulus(1'b1, 8'd4, 8'h00, 1'b0);
      applyStimulus(1'b0, 8'd4, 8'hAA, 1'b1);
      applyStimulus(1'b0, 8'd4, 8'h55, 1'b0);
      applyStimulus(1'b1, 8'd8, 8'h66, 1'b0);
      applyStimulus(1'b0, 8'd8, 8'hBB, 1'b1);
      applyStimulus(1'b0, 8'd8, 8'hCC, 1'b1);
      applyStimulus(1'b0, 8'd8, 8'h77, 1'b0);
      applyStimulus(1'b0, 8'd8, 8'hDD, 1'b1);
      checkWrite("t4_w0", 32'h0000_0000, 32'hDDCC_BBAA, 4'hF);
      endLoad(8'h0E, 1'b0);
      checkOutput("t4_wecount", weCount - weBase, 32'd1);

      // Reset in the middle of a word discards it.
      $display("[TB] reset after 3 of 4 bytes");
      weBase = weCount;
      applyStimulus(1'b1, 8'd4, 8'h00, 1'b0);
      pushByte(8'hA1); pushByte(8'hA2); pushByte(8'hA3);
      RST_N = 1'b0;
      applyStimulus(1'b0, 8'd0, 8'h00, 1'b0);
      checkAllZero("t5_rst");
      RST_N = 1'b1;
      checkOutput("t5_wecount", weCount - weBase, 32'd0);
      applyStimulus(1'b1, 8'd4, 8'h00, 1'b0);
      pushByte(8'h11); pushByte(8'h22); pushByte(8'h33); pushByte(8'h44);
      checkWrite("t5_w0", 32'h0000_0000, 32'h4433_2211, 4'hF);
      endLoad(8'hAA, 1'b0);
      checkOutput("t5_wecount2", weCount - weBase, 32'd1);

`ifdef LOADER_CHECKSUM_EN
      $display("[TB] checksum good and bad");
      applyStimulus(1'b1, 8'd2, 8'h00, 1'b0);
      pushByte(8'h10); pushByte(8'h20);
      checkWrite("t6_w0", 32'h0000_0000, 32'h0000_2010, 4'h3);
      endLoad(8'h30, 1'b0);
      applyStimulus(1'b1, 8'd2, 8'h00, 1'b0);
      pushByte(8'h10); pushByte(8'h20);
      checkWrite("t6_w1", 32'h0000_0000, 32'h0000_2010, 4'h3);
      endLoad(8'h31, 1'b1);
`endif

      $display("End of test - %0d assertions evaluated, %0d failures", nAsserts, nFails);
      $finish;
   end

endmodule
